// File: rtl/shot_turn_if.sv
// Bundle of keyboard, ball-status and score/turn signals between the turn
// sequencer and its neighbours (keyboard decoder, ball movers, score display).
interface shot_turn_if #(
    parameter int NUM_BALLS = 4
) ();
    logic                 startOfFrame;
    logic                 keyUp;
    logic                 keyDown;
    logic                 keyLeft;
    logic                 keyRight;
    logic                 keyEnter;
    logic [NUM_BALLS-1:0] ballMoving;
    logic [NUM_BALLS-1:0] ballPocketed;
    logic                 chargeUp;
    logic                 chargeDown;
    logic                 chargeLeft;
    logic                 chargeRight;
    logic                 releaseBall;
    logic                 whiteRespawn;
    logic                 currentPlayer;
    logic                 foul;
    logic [3:0]           scoreP0;
    logic [3:0]           scoreP1;
    logic                 gameOver;
    logic [2:0]           stateOut;

    modport master (
        output startOfFrame, keyUp, keyDown, keyLeft, keyRight, keyEnter,
        output ballMoving, ballPocketed,
        input  chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall,
        input  whiteRespawn, currentPlayer, foul, scoreP0, scoreP1, gameOver, stateOut
    );

    modport slave (
        input  startOfFrame, keyUp, keyDown, keyLeft, keyRight, keyEnter,
        input  ballMoving, ballPocketed,
        output chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall,
        output whiteRespawn, currentPlayer, foul, scoreP0, scoreP1, gameOver, stateOut
    );
endinterface

// File: rtl/shot_turn_controller.sv
// Billiard turn sequencer: gates aim/charge key pulses, releases the shot, waits
// for the table to settle, then resolves pockets, fouls, scores and player change.
module shot_turn_controller #(
    parameter int NUM_BALLS          = 4,
    parameter int SETTLE_FRAMES      = 8,
    parameter int AIM_TIMEOUT_FRAMES = 600
) (
    input logic         clk,
    input logic         resetN,
    shot_turn_if.slave  bus
);
    localparam logic [2:0] S_AIM       = 3'd0;
    localparam logic [2:0] S_SHOOT     = 3'd1;
    localparam logic [2:0] S_ROLL      = 3'd2;
    localparam logic [2:0] S_SETTLE    = 3'd3;
    localparam logic [2:0] S_TURN_END  = 3'd4;
    localparam logic [2:0] S_GAME_OVER = 3'd5;

    localparam int OBJ_N = NUM_BALLS - 1;
    localparam int AIM_W = $clog2(AIM_TIMEOUT_FRAMES + 1);
    localparam int SET_W = $clog2(SETTLE_FRAMES + 1);
    localparam logic [AIM_W-1:0] AIM_LIMIT = AIM_W'(AIM_TIMEOUT_FRAMES);
    localparam logic [SET_W-1:0] SET_LIMIT = SET_W'(SETTLE_FRAMES);

    function automatic logic [4:0] popcnt16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {2'b00, a} + {1'b0, b};
        if (s > 6'd15) begin
            return 4'd15;
        end else begin
            return s[3:0];
        end
    endfunction

    logic [2:0]       state_r,       state_nxt_s;
    logic [3:0]       charge_cnt_r,  charge_cnt_nxt_s;
    logic [AIM_W-1:0] aim_frames_r,  aim_frames_nxt_s;
    logic [SET_W-1:0] settle_cnt_r,  settle_cnt_nxt_s;
    logic             pot_obj_r,     pot_obj_nxt_s;
    logic             pot_white_r,   pot_white_nxt_s;
    logic             timeout_r,     timeout_nxt_s;
    logic [OBJ_N-1:0] potted_mask_r, potted_mask_nxt_s;
    logic [3:0]       charge_r,      charge_nxt_s;
    logic             release_r,     release_nxt_s;
    logic             respawn_r,     respawn_nxt_s;
    logic             player_r,      player_nxt_s;
    logic             foul_r,        foul_nxt_s;
    logic [3:0]       score0_r,      score0_nxt_s;
    logic [3:0]       score1_r,      score1_nxt_s;
    logic             game_over_r,   game_over_nxt_s;

    logic [3:0]       keys_s;
    logic [3:0]       fwd_s;
    logic             still_s;
    logic             track_s;
    logic [OBJ_N-1:0] obj_hit_s;
    logic [OBJ_N-1:0] obj_new_s;

    // Order is {up, down, left, right} throughout.
    assign keys_s    = {bus.keyUp, bus.keyDown, bus.keyLeft, bus.keyRight};
    assign still_s   = (bus.ballMoving == {NUM_BALLS{1'b0}});
    assign obj_hit_s = bus.ballPocketed[NUM_BALLS-1:1];
    assign obj_new_s = obj_hit_s & ~potted_mask_r;
    assign track_s   = (state_r == S_SHOOT) || (state_r == S_ROLL) || (state_r == S_SETTLE);

    // Next-state and next-output decode for the turn sequencer.
    always_comb begin
        state_nxt_s       = state_r;
        charge_cnt_nxt_s  = charge_cnt_r;
        aim_frames_nxt_s  = aim_frames_r;
        settle_cnt_nxt_s  = settle_cnt_r;
        pot_obj_nxt_s     = pot_obj_r;
        pot_white_nxt_s   = pot_white_r;
        timeout_nxt_s     = timeout_r;
        potted_mask_nxt_s = potted_mask_r;
        charge_nxt_s      = 4'b0000;
        release_nxt_s     = 1'b0;
        respawn_nxt_s     = 1'b0;
        player_nxt_s      = player_r;
        foul_nxt_s        = foul_r;
        score0_nxt_s      = score0_r;
        score1_nxt_s      = score1_r;
        game_over_nxt_s   = game_over_r;
        fwd_s             = 4'b0000;

        case (state_r)
            S_AIM: begin
                if (still_s) begin
                    fwd_s = keys_s;
                end else begin
                    fwd_s = 4'b0000;
                end
                charge_nxt_s     = fwd_s;
                charge_cnt_nxt_s = sat_add4(charge_cnt_r, popcnt16(16'(fwd_s)));
                // Enter is judged on the charge held before this cycle's keys.
                if (bus.keyEnter && (charge_cnt_r != 4'd0)) begin
                    state_nxt_s   = S_SHOOT;
                    release_nxt_s = 1'b1;
                end else if (bus.startOfFrame) begin
                    aim_frames_nxt_s = aim_frames_r + AIM_W'(1);
                    if ((aim_frames_r + AIM_W'(1)) == AIM_LIMIT) begin
                        timeout_nxt_s = 1'b1;
                        state_nxt_s   = S_TURN_END;
                    end else begin
                        state_nxt_s   = S_AIM;
                    end
                end else begin
                    state_nxt_s = S_AIM;
                end
            end
            S_SHOOT: begin
                charge_cnt_nxt_s = 4'd0;
                aim_frames_nxt_s = {AIM_W{1'b0}};
                foul_nxt_s       = 1'b0;
                pot_obj_nxt_s    = 1'b0;
                pot_white_nxt_s  = 1'b0;
                timeout_nxt_s    = 1'b0;
                state_nxt_s      = S_ROLL;
            end
            S_ROLL: begin
                if (bus.startOfFrame && still_s) begin
                    state_nxt_s      = S_SETTLE;
                    settle_cnt_nxt_s = SET_W'(1);
                end else begin
                    state_nxt_s      = S_ROLL;
                end
            end
            S_SETTLE: begin
                if (!bus.startOfFrame) begin
                    state_nxt_s = S_SETTLE;
                end else if (!still_s) begin
                    state_nxt_s      = S_ROLL;
                    settle_cnt_nxt_s = {SET_W{1'b0}};
                end else if ((settle_cnt_r + SET_W'(1)) == SET_LIMIT) begin
                    state_nxt_s      = S_TURN_END;
                    settle_cnt_nxt_s = {SET_W{1'b0}};
                end else begin
                    settle_cnt_nxt_s = settle_cnt_r + SET_W'(1);
                end
            end
            S_TURN_END: begin
                foul_nxt_s = pot_white_r | timeout_r;
                if (!pot_obj_r || foul_nxt_s) begin
                    player_nxt_s = ~player_r;
                end else begin
                    player_nxt_s = player_r;
                end
                if (potted_mask_r == {OBJ_N{1'b1}}) begin
                    state_nxt_s     = S_GAME_OVER;
                    game_over_nxt_s = 1'b1;
                end else begin
                    state_nxt_s      = S_AIM;
                    aim_frames_nxt_s = {AIM_W{1'b0}};
                end
            end
            S_GAME_OVER: begin
                state_nxt_s = S_GAME_OVER;
            end
            default: begin
                state_nxt_s = S_AIM;
            end
        endcase

        // Pocket pulses override the SHOOT clear so a pot in that cycle is kept.
        if (track_s) begin
            pot_white_nxt_s   = pot_white_nxt_s | bus.ballPocketed[0];
            pot_obj_nxt_s     = pot_obj_nxt_s | (|obj_hit_s);
            potted_mask_nxt_s = potted_mask_r | obj_hit_s;
            if (player_r) begin
                score1_nxt_s = sat_add4(score1_r, popcnt16(16'(obj_new_s)));
            end else begin
                score0_nxt_s = sat_add4(score0_r, popcnt16(16'(obj_new_s)));
            end
        end else begin
            potted_mask_nxt_s = potted_mask_r;
        end

        respawn_nxt_s = (state_nxt_s == S_TURN_END) && pot_white_nxt_s;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r       <= S_AIM;
            charge_cnt_r  <= 4'd0;
            aim_frames_r  <= {AIM_W{1'b0}};
            settle_cnt_r  <= {SET_W{1'b0}};
            pot_obj_r     <= 1'b0;
            pot_white_r   <= 1'b0;
            timeout_r     <= 1'b0;
            potted_mask_r <= {OBJ_N{1'b0}};
            charge_r      <= 4'b0000;
            release_r     <= 1'b0;
            respawn_r     <= 1'b0;
            player_r      <= 1'b0;
            foul_r        <= 1'b0;
            score0_r      <= 4'd0;
            score1_r      <= 4'd0;
            game_over_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            charge_cnt_r  <= charge_cnt_nxt_s;
            aim_frames_r  <= aim_frames_nxt_s;
            settle_cnt_r  <= settle_cnt_nxt_s;
            pot_obj_r     <= pot_obj_nxt_s;
            pot_white_r   <= pot_white_nxt_s;
            timeout_r     <= timeout_nxt_s;
            potted_mask_r <= potted_mask_nxt_s;
            charge_r      <= charge_nxt_s;
            release_r     <= release_nxt_s;
            respawn_r     <= respawn_nxt_s;
            player_r      <= player_nxt_s;
            foul_r        <= foul_nxt_s;
            score0_r      <= score0_nxt_s;
            score1_r      <= score1_nxt_s;
            game_over_r   <= game_over_nxt_s;
        end
    end

    assign bus.chargeUp      = charge_r[3];
    assign bus.chargeDown    = charge_r[2];
    assign bus.chargeLeft    = charge_r[1];
    assign bus.chargeRight   = charge_r[0];
    assign bus.releaseBall   = release_r;
    assign bus.whiteRespawn  = respawn_r;
    assign bus.currentPlayer = player_r;
    assign bus.foul          = foul_r;
    assign bus.scoreP0       = score0_r;
    assign bus.scoreP1       = score1_r;
    assign bus.gameOver      = game_over_r;
    assign bus.stateOut      = state_r;

endmodule

// File: tb/tb_shot_turn_controller.sv
// Directed bench for shot_turn_controller: walks aim, shot, roll, settle, pockets,
// timeout, game over and mid-roll reset against hand-computed values.
module tb_shot_turn_controller;
    logic clk;
    logic resetN;
    int   n_checks;
    int   n_errors;

    shot_turn_if #(.NUM_BALLS(4)) bus ();

    shot_turn_controller #(
        .NUM_BALLS(4),
        .SETTLE_FRAMES(8),
        .AIM_TIMEOUT_FRAMES(600)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus)
    );

    logic [19:0] outs_s;
    assign outs_s = {bus.chargeUp, bus.chargeDown, bus.chargeLeft, bus.chargeRight,
                     bus.releaseBall, bus.whiteRespawn, bus.currentPlayer, bus.foul,
                     bus.scoreP0, bus.scoreP1, bus.gameOver, bus.stateOut};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        cyc();
        bus.startOfFrame = 1'b0;
    endtask

    task automatic clear_keys();
        bus.keyUp    = 1'b0;
        bus.keyDown  = 1'b0;
        bus.keyLeft  = 1'b0;
        bus.keyRight = 1'b0;
        bus.keyEnter = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetN = 1'b0;
        bus.startOfFrame = 1'b0;
        clear_keys();
        bus.ballMoving   = 4'b0000;
        bus.ballPocketed = 4'b0000;
        repeat (2) cyc();
        chk("rst_outs", 32'(outs_s), 32'd0);
        resetN = 1'b1;
        cyc();
        chk("rst_state", 32'(bus.stateOut), 32'd0);

        // Enter with no charge, key while moving, direction+Enter together
        bus.keyEnter = 1'b1; cyc(); clear_keys();
        chk("enter_nochg_state", 32'(bus.stateOut), 32'd0);
        chk("enter_nochg_rel", 32'(bus.releaseBall), 32'd0);
        bus.ballMoving = 4'b0001; bus.keyDown = 1'b1; cyc(); clear_keys(); bus.ballMoving = 4'b0000;
        chk("key_moving_dropped", 32'(bus.chargeDown), 32'd0);
        bus.keyLeft = 1'b1; bus.keyEnter = 1'b1; cyc(); clear_keys();
        chk("left_enter_left", 32'(bus.chargeLeft), 32'd1);
        chk("left_enter_up", 32'(bus.chargeUp), 32'd0);
        chk("left_enter_state", 32'(bus.stateOut), 32'd0);
        chk("left_enter_rel", 32'(bus.releaseBall), 32'd0);

        // Charge up twice, then shoot
        bus.keyUp = 1'b1; cyc(); clear_keys();
        chk("up1_pulse", 32'(bus.chargeUp), 32'd1);
        cyc();
        chk("up1_width", 32'(bus.chargeUp), 32'd0);
        bus.keyUp = 1'b1; cyc(); clear_keys();
        chk("up2_pulse", 32'(bus.chargeUp), 32'd1);
        bus.keyEnter = 1'b1; cyc(); clear_keys();
        chk("shoot_state", 32'(bus.stateOut), 32'd1);
        chk("shoot_rel", 32'(bus.releaseBall), 32'd1);
        cyc();
        chk("roll_state", 32'(bus.stateOut), 32'd2);
        chk("roll_rel", 32'(bus.releaseBall), 32'd0);

        // Roll, abort a settle, then settle exactly 8 frames
        bus.ballMoving = 4'b0001;
        repeat (20) frame();
        chk("moving_roll", 32'(bus.stateOut), 32'd2);
        bus.ballMoving = 4'b0000;
        repeat (3) frame();
        chk("settle_enter", 32'(bus.stateOut), 32'd3);
        bus.ballMoving = 4'b0001; frame(); bus.ballMoving = 4'b0000;
        chk("settle_abort", 32'(bus.stateOut), 32'd2);
        repeat (7) frame();
        chk("settle_7", 32'(bus.stateOut), 32'd3);
        frame();
        chk("settle_8_turn_end", 32'(bus.stateOut), 32'd4);
        chk("no_pot_respawn", 32'(bus.whiteRespawn), 32'd0);
        cyc();
        chk("t3_state", 32'(bus.stateOut), 32'd0);
        chk("t3_player", 32'(bus.currentPlayer), 32'd1);
        chk("t3_foul", 32'(bus.foul), 32'd0);

        // Player 1 pots balls 1 and 2; repeat pulse of ball 1 not counted
        bus.keyRight = 1'b1; cyc(); clear_keys();
        chk("right_pulse", 32'(bus.chargeRight), 32'd1);
        bus.keyEnter = 1'b1; cyc(); clear_keys();
        chk("p1_shoot", 32'(bus.stateOut), 32'd1);
        cyc();
        bus.ballMoving = 4'b0001;
        bus.ballPocketed = 4'b0110; cyc(); bus.ballPocketed = 4'b0000;
        chk("pot2_p1", 32'(bus.scoreP1), 32'd2);
        chk("pot2_p0", 32'(bus.scoreP0), 32'd0);
        bus.ballPocketed = 4'b0010; cyc(); bus.ballPocketed = 4'b0000;
        chk("pot_repeat", 32'(bus.scoreP1), 32'd2);
        bus.ballMoving = 4'b0000;
        repeat (8) frame();
        chk("t4_turn_end", 32'(bus.stateOut), 32'd4);
        cyc();
        chk("t4_player_stays", 32'(bus.currentPlayer), 32'd1);
        chk("t4_foul", 32'(bus.foul), 32'd0);

        // Aim timeout after 600 frames
        repeat (599) frame();
        chk("timeout_599", 32'(bus.stateOut), 32'd0);
        frame();
        chk("timeout_600", 32'(bus.stateOut), 32'd4);
        chk("timeout_rel", 32'(bus.releaseBall), 32'd0);
        cyc();
        chk("timeout_foul", 32'(bus.foul), 32'd1);
        chk("timeout_player", 32'(bus.currentPlayer), 32'd0);
        chk("timeout_aim", 32'(bus.stateOut), 32'd0);

        // White + last object ball potted: foul, respawn, toggle, game over
        bus.keyUp = 1'b1; cyc(); clear_keys();
        bus.keyEnter = 1'b1; cyc(); clear_keys();
        chk("t5_rel", 32'(bus.releaseBall), 32'd1);
        cyc();
        chk("t5_foul_cleared", 32'(bus.foul), 32'd0);
        bus.ballMoving = 4'b0001;
        bus.ballPocketed = 4'b1001; cyc(); bus.ballPocketed = 4'b0000;
        chk("t5_score_p0", 32'(bus.scoreP0), 32'd1);
        chk("t5_score_p1", 32'(bus.scoreP1), 32'd2);
        bus.ballMoving = 4'b0000;
        repeat (8) frame();
        chk("t5_turn_end", 32'(bus.stateOut), 32'd4);
        chk("t5_respawn", 32'(bus.whiteRespawn), 32'd1);
        cyc();
        chk("go_state", 32'(bus.stateOut), 32'd5);
        chk("go_flag", 32'(bus.gameOver), 32'd1);
        chk("go_foul", 32'(bus.foul), 32'd1);
        chk("go_player", 32'(bus.currentPlayer), 32'd1);
        chk("respawn_width", 32'(bus.whiteRespawn), 32'd0);
        bus.keyUp = 1'b1; bus.keyEnter = 1'b1; bus.ballPocketed = 4'b0110; bus.startOfFrame = 1'b1;
        cyc();
        clear_keys(); bus.ballPocketed = 4'b0000; bus.startOfFrame = 1'b0;
        cyc();
        chk("go_frozen", 32'(outs_s), 32'({4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 4'd2, 1'b1, 3'd5}));

        // Reset out of game over, then reset mid-roll
        resetN = 1'b0; cyc(); resetN = 1'b1;
        chk("go_reset", 32'(outs_s), 32'd0);
        bus.keyUp = 1'b1; cyc(); clear_keys();
        bus.keyEnter = 1'b1; cyc(); clear_keys();
        cyc();
        chk("g_roll", 32'(bus.stateOut), 32'd2);
        bus.ballMoving = 4'b0001;
        bus.ballPocketed = 4'b0010; cyc(); bus.ballPocketed = 4'b0000;
        chk("g_score", 32'(bus.scoreP0), 32'd1);
        resetN = 1'b0; cyc();
        chk("midroll_reset", 32'(outs_s), 32'd0);
        resetN = 1'b1; bus.ballMoving = 4'b0000; cyc();
        chk("post_reset_aim", 32'(bus.stateOut), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
